uart_tx_fifo: RTL

Parametrised UART transmitter with a built-in transmit FIFO, a valid/ready input handshake and configurable frame format: data width, parity mode and stop-bit count. It sits between any byte/word producer in the design and the serial TX pin. It supersedes the fixed 8N1, single-shot transmitter and gives back-to-back framing with no idle gap.

---
 rtl/uart_tx_fifo_if.sv | 17 +
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if: valid/ready write channel into the UART transmit FIFO.
//   in_valid  producer -> FIFO  word present on in_data
//   in_data   producer -> FIFO  DATA_BITS-wide word to transmit
//   in_ready  FIFO -> producer  FIFO can accept (not full)
// Modports: master = producer side, slave = UART side.
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo: UART transmitter with a built-in transmit FIFO and a
// configurable frame (DATA_BITS 5..9, PARITY none/odd/even, 1 or 2 stops).
// Frames are sent back to back while the FIFO holds data.
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   s_if        write channel (in_valid / in_data / in_ready)
//   tx_out      serial line, idle high, registered
//   busy        high from the start bit through the last stop-bit cycle
//   tx_done     one-cycle pulse in the last cycle of the final stop bit
//   fifo_count  current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 s_if,
  output logic                          tx_out,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CPB   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BW    = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  localparam logic [BW-1:0]    BAUD_LAST = BW'(CPB - 1);
  localparam logic [BW-1:0]    BAUD_PEN  = BW'(CPB - 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr, r_rd;
  logic [CW-1:0]        r_count, w_count_nxt;
  logic                 r_ready;
  logic [BW-1:0]        r_baud;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt, w_head;
  logic                 r_par, w_par_head;
  logic                 r_tx_out, r_busy, r_done;
  logic                 w_tx_nxt, w_busy_nxt, w_done_nxt;
  logic                 w_push, w_pop, w_not_empty, w_baud_end;

  assign w_head      = r_mem[r_rd];
  assign w_not_empty = (r_count != '0);
  assign w_push      = s_if.in_valid && r_ready;
  assign w_baud_end  = (r_baud == BAUD_LAST);
  // Parity is taken from the word as popped, before any shifting.
  assign w_par_head  = (PARITY == 1) ? ~^w_head : ^w_head;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign s_if.in_ready = r_ready;
  assign fifo_count    = r_count;
  assign tx_out        = r_tx_out;
  assign busy          = r_busy;
  assign tx_done       = r_done;

  // FIFO storage (contents are don't-care after reset)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= s_if.in_data;
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; a pop happens on leaving IDLE or the final stop bit
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          w_state_nxt = S_START;
          w_pop       = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_baud_end && (r_bit == DATA_LAST))
          w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_baud_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_baud_end && (r_bit == STOP_LAST)) begin
          if (w_not_empty) begin
            w_state_nxt = S_START;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register next value: load on pop, shift at each data-bit boundary
  always_comb begin
    w_shreg_nxt = r_shreg;
    if (w_pop)
      w_shreg_nxt = w_head;
    else if ((r_state == S_DATA) && w_baud_end)
      w_shreg_nxt = r_shreg >> 1;
  end

  // Baud and bit counters; bit counter restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
    end else begin
      if (w_pop || w_baud_end)     r_baud <= '0;
      else if (r_state != S_IDLE)  r_baud <= r_baud + BW'(1);
      if (w_pop || (w_state_nxt != r_state)) r_bit <= '0;
      else if (w_baud_end)                   r_bit <= r_bit + BIT_W'(1);
      r_shreg <= w_shreg_nxt;
      if (w_pop) r_par <= w_par_head;
    end
  end

  // FSM outputs, computed one cycle ahead so the line is driven from flops
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    // tx_done lands in the last cycle of the final stop bit
    w_done_nxt = (r_state == S_STOP) && (r_bit == STOP_LAST) && (r_baud == BAUD_PEN);
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shreg_nxt[0];
      S_PARITY: w_tx_nxt = r_par;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_out <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tx_out <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

endmodule
